// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), derived totals and a
// ceil(log2) helper used when sizing scan counters.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_scan_if.sv
// Scan-generator bus: pixel-rate enable and pause in, scan position,
// sync, blanking and tick outputs back to the pixel pipeline and DAC side.
interface vga_scan_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          clk_en;
    logic          pause;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          line_tick;
    logic          frame_tick;

    modport master (
        input  clk_en, pause,
        output pixel_x, pixel_y, hsync, vsync, video_on, line_tick, frame_tick
    );

    modport slave (
        output clk_en, pause,
        input  pixel_x, pixel_y, hsync, vsync, video_on, line_tick, frame_tick
    );
endinterface

// File: rtl/vga_scan_gen_scan_counter.sv
// Modulo-N up counter with a combinational terminal-count flag; used once
// for the horizontal position and once for the vertical position.
module scan_counter #(
    parameter int WIDTH   = 10,
    parameter int MODULUS = 800
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    assign wrap = (count == LAST);

    // Step on enable, folding back to zero after the last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster timing generator: horizontal/vertical scan counters plus the
// sync, blanking and tick decode. Define VGA_SCAN_REG_OUT_EN to register
// every output (one clk of latency, glitch-free sync pins).
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY_P = H_DISPLAY,
    parameter int H_FRONT_P   = H_FRONT,
    parameter int H_SYNC_P    = H_SYNC,
    parameter int H_BACK_P    = H_BACK,
    parameter int V_DISPLAY_P = V_DISPLAY,
    parameter int V_FRONT_P   = V_FRONT,
    parameter int V_SYNC_P    = V_SYNC,
    parameter int V_BACK_P    = V_BACK,
    parameter bit SYNC_POL    = 1'b0,
    parameter int XW          = 10,
    parameter int YW          = 10
) (
    input  logic       clk,
    input  logic       reset,
    vga_scan_if.master bus
);
    localparam int H_TOT = H_DISPLAY_P + H_FRONT_P + H_SYNC_P + H_BACK_P;
    localparam int V_TOT = V_DISPLAY_P + V_FRONT_P + V_SYNC_P + V_BACK_P;

    // Window edges pre-truncated to the counter widths for unsigned compares.
    localparam logic [XW-1:0] H_VIS_END  = XW'(H_DISPLAY_P);
    localparam logic [XW-1:0] H_SYNC_BEG = XW'(H_DISPLAY_P + H_FRONT_P);
    localparam logic [XW-1:0] H_SYNC_END = XW'(H_DISPLAY_P + H_FRONT_P + H_SYNC_P);
    localparam logic [YW-1:0] V_VIS_END  = YW'(V_DISPLAY_P);
    localparam logic [YW-1:0] V_SYNC_BEG = YW'(V_DISPLAY_P + V_FRONT_P);
    localparam logic [YW-1:0] V_SYNC_END = YW'(V_DISPLAY_P + V_FRONT_P + V_SYNC_P);

    logic          advance;
    logic [XW-1:0] h_count;
    logic [YW-1:0] v_count;
    logic          h_wrap;
    logic          v_wrap;

    logic hsync_next;
    logic vsync_next;
    logic video_on_next;
    logic line_tick_next;
    logic frame_tick_next;

    // Pause wins over the pixel enable.
    assign advance = bus.clk_en & ~bus.pause;

    scan_counter #(.WIDTH(XW), .MODULUS(H_TOT)) u_h_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (advance),
        .count  (h_count),
        .wrap   (h_wrap)
    );

    scan_counter #(.WIDTH(YW), .MODULUS(V_TOT)) u_v_counter (
        .clk    (clk),
        .reset  (reset),
        .enable (advance & h_wrap),
        .count  (v_count),
        .wrap   (v_wrap)
    );

    // Interpret the counts as sync, blanking and end-of-line/frame pulses.
    always_comb begin
        hsync_next      = ((h_count >= H_SYNC_BEG) && (h_count < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_next      = ((v_count >= V_SYNC_BEG) && (v_count < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        video_on_next   = (h_count < H_VIS_END) && (v_count < V_VIS_END);
        line_tick_next  = advance & h_wrap;
        frame_tick_next = advance & h_wrap & v_wrap;
    end

`ifdef VGA_SCAN_REG_OUT_EN
    logic [XW-1:0] pixel_x_reg;
    logic [YW-1:0] pixel_y_reg;
    logic          hsync_reg;
    logic          vsync_reg;
    logic          video_on_reg;
    logic          line_tick_reg;
    logic          frame_tick_reg;

    // Retime every output by one clock so the pins never see decode glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_x_reg    <= '0;
            pixel_y_reg    <= '0;
            hsync_reg      <= ~SYNC_POL;
            vsync_reg      <= ~SYNC_POL;
            video_on_reg   <= 1'b0;
            line_tick_reg  <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            pixel_x_reg    <= h_count;
            pixel_y_reg    <= v_count;
            hsync_reg      <= hsync_next;
            vsync_reg      <= vsync_next;
            video_on_reg   <= video_on_next;
            line_tick_reg  <= line_tick_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign bus.pixel_x    = pixel_x_reg;
    assign bus.pixel_y    = pixel_y_reg;
    assign bus.hsync      = hsync_reg;
    assign bus.vsync      = vsync_reg;
    assign bus.video_on   = video_on_reg;
    assign bus.line_tick  = line_tick_reg;
    assign bus.frame_tick = frame_tick_reg;
`else
    assign bus.pixel_x    = h_count;
    assign bus.pixel_y    = v_count;
    assign bus.hsync      = hsync_next;
    assign bus.vsync      = vsync_next;
    assign bus.video_on   = video_on_next;
    assign bus.line_tick  = line_tick_next;
    assign bus.frame_tick = frame_tick_next;
`endif
endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

VGA raster timing generator that turns a pixel-rate enable into horizontal and vertical scan positions plus sync, blanking and tick outputs. It sits between the pixel clock-enable source and the Mandelbrot pixel pipeline and the video DAC interface. Its outputs say which pixel is being scanned and whether it is visible, so the downstream iteration engine and frame buffer reader know what to fetch or compute. It is the decode end of the scan counters: it counts and also interprets the counts as VGA timing.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- XW, 10, pixel_x width; must hold H_TOTAL-1
- YW, 10, pixel_y width; must hold V_TOTAL-1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  pixel-rate enable; the scan advances only on cycles where this is high
- pause  in  1  freeze the scan; overrides clk_en
- pixel_x  out  XW  current horizontal count
- pixel_y  out  YW  current vertical count
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high inside the visible region
- line_tick  out  1  one-cycle pulse on the last advance of each line
- frame_tick  out  1  one-cycle pulse on the last advance of each frame

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- advance = clk_en && !pause. If pause and clk_en are both high, the scan holds.
- Horizontal count h:
  - Increments on advance.
  - Goes from H_TOTAL-1 back to 0.
- Vertical count v:
  - Increments on an advance where h == H_TOTAL-1.
  - Goes from V_TOTAL-1 back to 0 on that same advance.
- hsync is active while H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_SYNC (656..751). Otherwise it sits at the inactive level.
- vsync is active while V_DISPLAY+V_FRONT <= v < V_DISPLAY+V_FRONT+V_SYNC (490..491).
- video_on = (h < H_DISPLAY) && (v < V_DISPLAY).
- line_tick = advance && h == H_TOTAL-1.
- frame_tick = line_tick && v == V_TOTAL-1.
- Both ticks are gated by advance, so they never fire while paused or while clk_en is low.
- pixel_x = h and pixel_y = v, zero-extended to XW and YW.
- Comparisons use unsigned arithmetic. Parameter sums are computed at elaboration, at least 32 bits wide.

## Timing
- Reset (asynchronous) clears h and v to 0.
  - Output values during reset:
    - pixel_x = pixel_y = 0.
    - hsync = vsync = inactive (!SYNC_POL).
    - line_tick = frame_tick = 0.
  - video_on during reset: 1 unregistered, 0 registered.
  - The first advance after reset is released moves h from 0 to 1.
- Reset mid-frame aborts immediately. There is no partial-line completion.
- Unregistered build: outputs are a combinational decode of the h/v registers, so they change in the same cycle as the count.
- Registered build: every output is exactly one clk later than the unregistered build. The lag is one clock, not one advance.
- Holding clk_en low freezes all outputs except the ticks. The ticks stay at 0.

## Configuration
- Macro: VGA_SCAN_REG_OUT_EN.
- When defined: all outputs come from registers, giving glitch-free sync for the pins.
  - Latency is +1 clk.
  - Outputs reset to the values above, with video_on = 0.
- When undefined: outputs decode combinationally from the counters with zero latency.
  - video_on = 1 during reset, since h = v = 0.

## Structure
- Shared package vga_timing_pkg:
  - Default 640x480@60 constants (H_/V_ DISPLAY, FRONT, SYNC, BACK).
  - Derived H_TOTAL and V_TOTAL.
  - Helper function clog2 for width checks.
- One sub-module, scan_counter. Used twice: horizontal and vertical.
  - Parameters: width and modulus.
  - Inputs: enable.
  - Outputs: count and a combinational wrap flag, asserted when count == modulus-1.
  - Vertical enable = advance && horizontal wrap flag.
- Top level: sync/blank decode and the optional output register stage.

## Test plan
- Reset, then clk_en = 1 constantly (unregistered build): h steps 0..799. line_tick is high only in the cycle where pixel_x = 799, and the next cycle shows pixel_x = 0, pixel_y = 1.
- hsync window: hsync is low for exactly 96 advances, first with pixel_x = 656, last with pixel_x = 751. video_on drops at pixel_x = 640.
- Full frame: vsync is low for lines 490–491 (1600 advances). frame_tick pulses exactly once per 420000 advances, at (799, 524), and the count returns to (0, 0).
- clk_en high every other cycle: one line takes 1600 clocks, and line_tick is never high on a cycle where clk_en = 0.
- pause = 1 for 10 cycles at pixel_x = 300 with clk_en = 1: outputs hold at 300 with no ticks, and counting resumes at 301.
- Async reset asserted at (400, 200): outputs go to their reset values before the next clk edge. In the registered build, every output trails the unregistered reference model by exactly 1 clk.
